neuron_mac_ctrl: RTL and testbench
==================================

// Module: neuron_mac_ctrl
// PURPOSE
//  Sequencer for one neuron. Shares a single N-bit sign-magnitude fixed-point multiplier
//  (MSB = sign, N-1 fraction bits) across K input/weight pairs.
//  Per element: reads a[i] and w[i] from external memories, drives the multiplier, and
//  accumulates the products in two's complement.
//  After the last element, returns a saturated sign-magnitude result with a done pulse.
// PARAMETERS
//  N       8   data width, sign-magnitude: 1 sign bit + N-1 fraction bits
//  K       4   number of input/weight pairs per neuron (K >= 1)
//  ADDR_W  2   memory address width; 2**ADDR_W >= K
//  ACC_W   12  accumulator width, two's complement; ACC_W >= N+clog2(K)
// PORTS
//  clk      in   1       clock, rising edge
//  rst      in   1       asynchronous reset, active high
//  start    in   1       start request; sampled only in IDLE
//  rd_en    out  1       memory read strobe; data returns on the next cycle
//  addr     out  ADDR_W  element index i for the a and w memories
//  a_in     in   N       activation read data, valid the cycle after rd_en
//  w_in     in   N       weight read data, valid the cycle after rd_en
//  mul_a    out  N       multiplier operand a (registered)
//  mul_w    out  N       multiplier operand w (registered)
//  mul_out  in   N       multiplier result, combinational from mul_a/mul_w
//  busy     out  1       high in every state except IDLE
//  done     out  1       one-cycle pulse; y is valid from this cycle on
//  y        out  N       neuron result, sign-magnitude, saturated; held until the next done
// BEHAVIOUR
//  Reset state (async, all outputs)
//   - state=IDLE
//   - rd_en=0, addr=0, mul_a=0, mul_w=0, busy=0, done=0, y=0
//   - accumulator=0, element counter=0
//  FSM
//   - IDLE -start-> FETCH; accumulator and counter are cleared on the same edge.
//   - FETCH: rd_en=1, addr=i. Next state LOAD.
//   - LOAD: mul_a<=a_in, mul_w<=w_in. Next state ACC.
//   - ACC: acc<=acc+sm2tc(mul_out).
//       - if i==K-1: next state DONE.
//       - else: i<=i+1, next state FETCH.
//   - DONE: done=1, y<=sat(acc). Next state IDLE.
//  Latency: start sampled at cycle t -> done high at cycle t+3K+1 (t+13 for K=4).
//  rd_en is high only in FETCH. addr holds its last value otherwise.
//  sm2tc: magnitude zero-extended to ACC_W bits, negated when sign=1.
//   - Negative zero (sign=1, magnitude=0) converts to 0.
//  sat(acc): MAXM = 2**(N-1)-1
//   - acc > MAXM   -> y = {0, all ones}
//   - acc < -MAXM  -> y = {1, all ones}
//   - acc == 0     -> y = 0 (never negative zero)
//   - otherwise    -> y = {sign(acc), |acc|[N-2:0]}
//  Boundary conditions
//   - start while busy: ignored, no queueing.
//   - start held high: a new run starts in the IDLE cycle right after DONE (back-to-back runs).
//   - rst mid-run: aborts immediately to the reset state. No done is issued.
//     y reverts to 0.
//   - The accumulator never wraps for ACC_W >= N+clog2(K). Saturation applies only at DONE.
// CONFIGURATION
//  NEURON_RELU_EN
//   - Defined: at DONE, a negative saturated result is replaced by y=0 (ReLU).
//     Latency is unchanged.
//   - Undefined: y is the signed saturated result as above.
// TESTING
//  Bench mul_out model: sign = a[N-1]^w[N-1]; magnitude = (|a|*|w|)>>(N-1).
//  All cases use defaults N=8, K=4.
//  1. Basic run
//     - Stimulus: a=[40,20,00,40], all w=40 (hex), start pulse at cycle t.
//     - Expect: rd_en at t+1,t+4,t+7,t+10 with addr 0..3.
//     - Expect: done at t+13 only, y=0x50.
//  2. Cancellation to zero
//     - Stimulus: a=[40,C0,40,C0], all w=40.
//     - Expect: y=0x00 (not 0x80).
//     - Stimulus: a=[C0,00,10,00], all w=40.
//     - Expect: y=0x98.
//  3. Saturation
//     - Stimulus: all a=7F, all w=7F.
//     - Expect: y=0x7F.
//     - Stimulus: all a=7F, all w=FF.
//     - Expect: y=0xFF; with NEURON_RELU_EN, y=0x00.
//  4. Handshake
//     - Stimulus: start pulsed mid-run.
//     - Expect: ignored; exactly one done; y unchanged until that done.
//     - Stimulus: start held high for 3 runs.
//     - Expect: done pulses spaced 3K+2=14 cycles apart.
//  5. Reset mid-run
//     - Stimulus: rst asserted during ACC of element 2, then test 1 rerun.
//     - Expect: all outputs 0 asynchronously, no done; rerun gives y=0x50 (no stale accumulation).

Source files
------------

// File: rtl/neuron_mac_ctrl.sv
// neuron_mac_ctrl: sequencer that time-shares one sign-magnitude multiplier across K pairs.
// Build option NEURON_RELU_EN: a negative result is forced to zero at DONE (ReLU).
module neuron_mac_ctrl #(
  parameter int N      = 8,
  parameter int K      = 4,
  parameter int ADDR_W = 2,
  parameter int ACC_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  input  logic [N-1:0]      a_in,
  input  logic [N-1:0]      w_in,
  output logic [N-1:0]      mul_a,
  output logic [N-1:0]      mul_w,
  input  logic [N-1:0]      mul_out,
  output logic              busy,
  output logic              done,
  output logic [N-1:0]      y
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    ACC   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [ACC_W-1:0]  MAXM = ACC_W'((1 << (N - 1)) - 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(K - 1);

  state_t              state_reg;
  logic [ADDR_W-1:0]   cnt_reg;
  logic [ACC_W-1:0]    acc_reg;

  logic [ACC_W-1:0]    prod_mag;
  logic [ACC_W-1:0]    prod_tc;
  logic [ACC_W-1:0]    acc_sum;
  logic [ACC_W-1:0]    acc_abs;
  logic [N-1:0]        y_next;

  // Product conversion, running sum and the saturated result of that sum. The
  // result is taken from acc_sum so y is ready on the same edge that enters DONE.
  always_comb begin
    prod_mag          = '0;
    prod_mag[N-2:0]   = mul_out[N-2:0];
    // Negating a zero magnitude yields zero, so negative zero needs no special case.
    prod_tc           = mul_out[N-1] ? (~prod_mag + 1'b1) : prod_mag;
    acc_sum           = acc_reg + prod_tc;
    acc_abs           = acc_sum[ACC_W-1] ? (~acc_sum + 1'b1) : acc_sum;

    if (acc_abs > MAXM) begin
      y_next = {acc_sum[ACC_W-1], {(N-1){1'b1}}};
    end else if (acc_abs == '0) begin
      y_next = '0;
    end else begin
      y_next = {acc_sum[ACC_W-1], acc_abs[N-2:0]};
    end

`ifdef NEURON_RELU_EN
    if (y_next[N-1]) begin
      y_next = '0;
    end
`else
    y_next = y_next;
`endif
  end

  // Outputs are registered on the transition into the state that owns them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      rd_en     <= 1'b0;
      addr      <= '0;
      mul_a     <= '0;
      mul_w     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      y         <= '0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= FETCH;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            rd_en     <= 1'b1;
            addr      <= '0;
            busy      <= 1'b1;
          end
        end
        FETCH: begin
          state_reg <= LOAD;
        end
        LOAD: begin
          mul_a     <= a_in;
          mul_w     <= w_in;
          state_reg <= ACC;
        end
        ACC: begin
          acc_reg <= acc_sum;
          if (cnt_reg == LAST) begin
            state_reg <= DONE;
            done      <= 1'b1;
            y         <= y_next;
          end else begin
            cnt_reg   <= cnt_reg + 1'b1;
            addr      <= cnt_reg + 1'b1;
            rd_en     <= 1'b1;
            state_reg <= FETCH;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// Self-checking bench for neuron_mac_ctrl: directed spec cases plus random runs
// checked cycle by cycle against an arithmetic reference model.
module tb_neuron_mac_ctrl;

  localparam int N      = 8;
  localparam int K      = 4;
  localparam int ADDR_W = 2;
  localparam int ACC_W  = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [N-1:0]      a_in = '0;
  logic [N-1:0]      w_in = '0;
  logic [N-1:0]      mul_a;
  logic [N-1:0]      mul_w;
  logic [N-1:0]      mul_out;
  logic              busy;
  logic              done;
  logic [N-1:0]      y;

  logic [N-1:0] a_mem [K];
  logic [N-1:0] w_mem [K];
  logic [N-1:0] prev_y;

  int n_vec = 0;
  int n_err = 0;

  neuron_mac_ctrl #(.N(N), .K(K), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .addr(addr),
    .a_in(a_in), .w_in(w_in), .mul_a(mul_a), .mul_w(mul_w), .mul_out(mul_out),
    .busy(busy), .done(done), .y(y)
  );

  always #5 clk = ~clk;

  // External memories: one cycle of read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      a_in <= a_mem[addr];
      w_in <= w_mem[addr];
    end
  end

  function automatic logic [N-1:0] mul_model(input logic [N-1:0] a, input logic [N-1:0] w);
    int p;
    p = (int'(a[N-2:0]) * int'(w[N-2:0])) >> (N - 1);
    return {a[N-1] ^ w[N-1], 7'(p)};
  endfunction

  assign mul_out = mul_model(mul_a, mul_w);

  // Reference: signed integer dot product, then saturate to sign-magnitude.
  function automatic logic [N-1:0] ref_y();
    int acc;
    int mag;
    int maxm;
    logic [N-1:0] p;
    logic [N-1:0] r;
    acc  = 0;
    maxm = (1 << (N - 1)) - 1;
    for (int i = 0; i < K; i++) begin
      p   = mul_model(a_mem[i], w_mem[i]);
      mag = int'(p[N-2:0]);
      acc = p[N-1] ? acc - mag : acc + mag;
    end
    if (acc > maxm)       r = 8'h7F;
    else if (acc < -maxm) r = 8'hFF;
    else if (acc == 0)    r = 8'h00;
    else if (acc < 0)     r = {1'b1, 7'(-acc)};
    else                  r = {1'b0, 7'(acc)};
`ifdef NEURON_RELU_EN
    if (r[N-1]) r = 8'h00;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One or more runs from a start pulse; checks every cycle t+1..t+len.
  task automatic run(input string name, input bit hold, input bit mid, input int len);
    logic [N-1:0] exp_y;
    int nrun;
    int ph;
    int r;
    bit exp_rd;
    exp_y = ref_y();
    nrun  = hold ? 3 : 1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      ph = k % 14;
      r  = k / 14;
      exp_rd = (r < nrun) && (ph == 1 || ph == 4 || ph == 7 || ph == 10);
      chk({name, ".rd_en"}, 32'(rd_en), 32'(exp_rd));
      if (exp_rd) chk({name, ".addr"}, 32'(addr), 32'((ph - 1) / 3));
      chk({name, ".done"}, 32'(done), 32'((r < nrun) && ph == 13));
      chk({name, ".busy"}, 32'(busy), 32'((r < nrun) && ph >= 1));
      chk({name, ".y"}, 32'(y), 32'((k >= 13) ? exp_y : prev_y));
      start = (hold && k <= 28) || (mid && k == 5);
    end
    start = 1'b0;
    prev_y = exp_y;
    $display("run %s: y=%02h expected %02h", name, y, exp_y);
  endtask

  task automatic load_mem(input logic [31:0] a_word, input logic [31:0] w_word);
    for (int i = 0; i < K; i++) begin
      a_mem[i] = a_word[8*(K-1-i) +: 8];
      w_mem[i] = w_word[8*(K-1-i) +: 8];
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".rd_en"}, 32'(rd_en), 32'd0);
    chk({name, ".addr"},  32'(addr),  32'd0);
    chk({name, ".mul_a"}, 32'(mul_a), 32'd0);
    chk({name, ".mul_w"}, 32'(mul_w), 32'd0);
    chk({name, ".busy"},  32'(busy),  32'd0);
    chk({name, ".done"},  32'(done),  32'd0);
    chk({name, ".y"},     32'(y),     32'd0);
  endtask

  initial begin
    prev_y = '0;
    load_mem(32'h00000000, 32'h00000000);
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    load_mem(32'h40200040, 32'h40404040);
    run("basic", 1'b0, 1'b0, 16);
    load_mem(32'h40C040C0, 32'h40404040);
    run("cancel0", 1'b0, 1'b0, 16);
    load_mem(32'hC0001000, 32'h40404040);
    run("cancel98", 1'b0, 1'b0, 16);
    load_mem(32'h7F7F7F7F, 32'h7F7F7F7F);
    run("satpos", 1'b0, 1'b0, 16);
    load_mem(32'h7F7F7F7F, 32'hFFFFFFFF);
    run("satneg", 1'b0, 1'b0, 16);
    load_mem(32'h40200040, 32'h40404040);
    run("midstart", 1'b0, 1'b1, 18);
    load_mem(32'hC0001000, 32'h40404040);
    run("held", 1'b1, 1'b0, 45);

    // Abort during ACC of element 2 (cycle t+9).
    load_mem(32'h7F7F7F7F, 32'h7F7F7F7F);
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk_all_zero("rstmid");
    repeat (2) begin
      @(negedge clk);
      chk("rstmid.hold_done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    prev_y = '0;
    repeat (2) begin
      @(negedge clk);
      chk("rstmid.idle_busy", 32'(busy), 32'd0);
    end
    load_mem(32'h40200040, 32'h40404040);
    run("rerun", 1'b0, 1'b0, 16);

    for (int n = 0; n < 12; n++) begin
      load_mem($urandom, $urandom);
      run($sformatf("rand%0d", n), 1'b0, ($urandom_range(0, 3) == 0), 16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
